// File: rtl/clock_gating_mc_pkg.sv
// Shared definitions for the multi-channel clock-gating controller.
// Holds the channel state encoding and the default widths.
package clock_gating_mc_pkg;

  typedef enum logic {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } cg_state_e;

  localparam int DEF_CH_NUM = 4;
  localparam int DEF_IDLE_W = 8;
  localparam int DEF_STAT_W = 16;

endpackage

// File: rtl/cg_icg_cell.sv
// Latch-based integrated clock gate.
// The latch is transparent only while clk is low, so gclk never glitches or truncates.
module cg_icg_cell (
  input  logic clk,
  input  logic en,
  input  logic test_en,
  output logic gclk
);

  logic latch_q;

  always_latch begin
    if (!clk) latch_q <= en | test_en;
  end

  assign gclk = clk & latch_q;

endmodule

// File: rtl/clock_gating_mc.sv
// Multi-channel clock-gating controller: per-channel wake/idle FSM, ICG and
// saturating gated-cycle statistics counter.
//
// state  | meaning
// -------+------------------------------------------------------------
// ST_OFF | clock gated; waits for busy or sw_en
// ST_ON  | clock running; counts idle cycles up to idle_thr, then gates
module clock_gating_mc
  import clock_gating_mc_pkg::*;
#(
  parameter int CH_NUM = DEF_CH_NUM,
  parameter int IDLE_W = DEF_IDLE_W,
  parameter int STAT_W = DEF_STAT_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     test_en,
  input  logic [CH_NUM-1:0]        sw_en,
  input  logic [CH_NUM-1:0]        busy,
  input  logic [IDLE_W-1:0]        idle_thr,
  input  logic                     stat_clr,
  output logic [CH_NUM-1:0]        gclk,
  output logic [CH_NUM-1:0]        ch_on,
  output logic [CH_NUM*STAT_W-1:0] gate_cnt
);

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    cg_state_e         state_q, state_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [STAT_W-1:0] stat_q;
    logic              act;
    logic              en_q;

    assign act  = busy[i] | sw_en[i];
    assign en_q = (state_q == ST_ON);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        state_q <= ST_OFF;
        idle_q  <= '0;
      end else begin
        state_q <= state_d;
        idle_q  <= idle_d;
      end
    end

    // Live idle_thr compare with >= so lowering it mid-count gates at once.
    always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      case (state_q)
        ST_OFF: begin
          if (act) begin
            state_d = ST_ON;
            idle_d  = '0;
          end
        end
        ST_ON: begin
          if (act) begin
            idle_d = '0;
          end else if (idle_q >= idle_thr) begin
            state_d = ST_OFF;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          idle_d  = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        stat_q <= '0;
      end else if (stat_clr) begin
        stat_q <= '0;
      end else if (!en_q && !test_en && (stat_q != {STAT_W{1'b1}})) begin
        stat_q <= stat_q + 1'b1;
      end
    end

    cg_icg_cell u_icg (
      .clk     (clk),
      .en      (en_q),
      .test_en (test_en),
      .gclk    (gclk[i])
    );

    assign ch_on[i]                      = en_q;
    assign gate_cnt[i*STAT_W +: STAT_W]  = stat_q;
  end

endmodule

// File: tb/tb_clock_gating_mc.sv
// Self-checking bench for clock_gating_mc: default instance plus a 4-bit-stat
// instance sharing the same stimulus for saturation checks.
module tb_clock_gating_mc;

  localparam int CH  = 4;
  localparam int IW  = 8;
  localparam int SW  = 16;
  localparam int SWS = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          test_en;
  logic          stat_clr;
  logic [CH-1:0] sw_en;
  logic [CH-1:0] busy;
  logic [IW-1:0] idle_thr;

  logic [CH-1:0]     gclk, ch_on, gclk_s, ch_on_s;
  logic [CH*SW-1:0]  gate_cnt;
  logic [CH*SWS-1:0] gate_cnt_s;

  int     n_tests = 0;
  int     n_fail  = 0;
  longint exp_q[$];
  longint expv;

  int  ecnt[CH];
  time first_t[CH];
  time last_t[CH];
  time rise_t[CH] = '{default: 0};
  int  glitch = 0;

  always #5 clk = ~clk;

  clock_gating_mc #(.CH_NUM(CH), .IDLE_W(IW), .STAT_W(SW)) dut (
    .clk(clk), .rstn(rstn), .test_en(test_en), .sw_en(sw_en), .busy(busy),
    .idle_thr(idle_thr), .stat_clr(stat_clr), .gclk(gclk), .ch_on(ch_on),
    .gate_cnt(gate_cnt)
  );

  clock_gating_mc #(.CH_NUM(CH), .IDLE_W(IW), .STAT_W(SWS)) dut_sat (
    .clk(clk), .rstn(rstn), .test_en(test_en), .sw_en(sw_en), .busy(busy),
    .idle_thr(idle_thr), .stat_clr(stat_clr), .gclk(gclk_s), .ch_on(ch_on_s),
    .gate_cnt(gate_cnt_s)
  );

  for (genvar g = 0; g < CH; g++) begin : g_mon
    always @(posedge gclk[g]) begin
      ecnt[g]++;
      if (first_t[g] == 0) first_t[g] = $time;
      last_t[g] = $time;
      rise_t[g] = $time;
    end
    always @(negedge gclk[g]) begin
      if (rise_t[g] != 0 && ($time - rise_t[g]) != 5) glitch++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_edges();
    for (int i = 0; i < CH; i++) begin
      ecnt[i]    = 0;
      first_t[i] = 0;
      last_t[i]  = 0;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; test_en = 1'b0; stat_clr = 1'b0;
    sw_en = '0; busy = '0; idle_thr = 8'd4;
    clr_edges();
    repeat (3) tick();
    n_tests++;
    if (ch_on !== 4'b0000) begin n_fail++; $display("FAIL reset_ch_on: got %b expected 0000", ch_on); end
    n_tests++;
    if (gclk !== 4'b0000) begin n_fail++; $display("FAIL reset_gclk: got %b expected 0000", gclk); end
    n_tests++;
    if (gate_cnt !== '0) begin n_fail++; $display("FAIL reset_gate_cnt: got %h expected 0", gate_cnt); end
    rstn = 1'b1;
    clr_edges();
    exp_q.push_back(20);
    exp_q.push_back(15);
    repeat (20) tick();
    expv = exp_q.pop_front();
    for (int i = 0; i < CH; i++) begin
      n_tests++;
      if (longint'(gate_cnt[i*SW +: SW]) !== expv) begin
        n_fail++; $display("FAIL idle_gate_cnt[%0d]: got %0d expected %0d", i, gate_cnt[i*SW +: SW], expv);
      end
    end
    expv = exp_q.pop_front();
    for (int i = 0; i < CH; i++) begin
      n_tests++;
      if (longint'(gate_cnt_s[i*SWS +: SWS]) !== expv) begin
        n_fail++; $display("FAIL sat_gate_cnt[%0d]: got %0d expected %0d", i, gate_cnt_s[i*SWS +: SWS], expv);
      end
    end
    for (int i = 0; i < CH; i++) begin
      n_tests++;
      if (ecnt[i] !== 0) begin n_fail++; $display("FAIL idle_flat_gclk[%0d]: got %0d edges expected 0", i, ecnt[i]); end
    end
    n_tests++;
    if (ch_on !== 4'b0000) begin n_fail++; $display("FAIL idle_ch_on: got %b expected 0000", ch_on); end
  endtask

  task automatic test_stat_clr();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    n_tests++;
    if (gate_cnt !== '0) begin n_fail++; $display("FAIL stat_clr: got %h expected 0", gate_cnt); end
    n_tests++;
    if (gate_cnt_s !== '0) begin n_fail++; $display("FAIL stat_clr_sat: got %h expected 0", gate_cnt_s); end
  endtask

  task automatic test_busy_ch0();
    clr_edges();
    idle_thr = 8'd4;
    busy[0] = 1'b1;
    exp_q.push_back(longint'($time) + 19);
    exp_q.push_back(2 + 4 + 1);
    tick();
    n_tests++;
    if (ch_on[0] !== 1'b1) begin n_fail++; $display("FAIL busy0_wake: got %b expected 1", ch_on[0]); end
    tick();
    tick();
    busy[0] = 1'b0;
    repeat (12) tick();
    expv = exp_q.pop_front();
    n_tests++;
    if (longint'(first_t[0]) !== expv) begin
      n_fail++; $display("FAIL busy0_latency: got %0d expected %0d", first_t[0], expv);
    end
    expv = exp_q.pop_front();
    n_tests++;
    if (longint'(ecnt[0]) !== expv) begin n_fail++; $display("FAIL busy0_edges: got %0d expected %0d", ecnt[0], expv); end
    n_tests++;
    if (ch_on !== 4'b0000) begin n_fail++; $display("FAIL busy0_gated: got %b expected 0000", ch_on); end
    for (int i = 1; i < CH; i++) begin
      n_tests++;
      if (ecnt[i] !== 0) begin n_fail++; $display("FAIL busy0_others[%0d]: got %0d edges expected 0", i, ecnt[i]); end
    end
  endtask

  task automatic test_idle_thr();
    clr_edges();
    idle_thr = 8'd0;
    busy[1] = 1'b1;
    exp_q.push_back(1);
    tick();
    busy[1] = 1'b0;
    repeat (6) tick();
    expv = exp_q.pop_front();
    n_tests++;
    if (longint'(ecnt[1]) !== expv) begin n_fail++; $display("FAIL thr0_edges: got %0d expected %0d", ecnt[1], expv); end
    n_tests++;
    if (ch_on[1] !== 1'b0) begin n_fail++; $display("FAIL thr0_gated: got %b expected 0", ch_on[1]); end

    clr_edges();
    idle_thr = 8'd6;
    busy[1] = 1'b1;
    exp_q.push_back(3 + 6 + 1);
    exp_q.push_back(90);
    tick();
    busy[1] = 1'b0;
    tick();
    tick();
    busy[1] = 1'b1;
    tick();
    busy[1] = 1'b0;
    n_tests++;
    if (ch_on[1] !== 1'b1) begin n_fail++; $display("FAIL retrig_on: got %b expected 1", ch_on[1]); end
    repeat (12) tick();
    expv = exp_q.pop_front();
    n_tests++;
    if (longint'(ecnt[1]) !== expv) begin n_fail++; $display("FAIL retrig_edges: got %0d expected %0d", ecnt[1], expv); end
    expv = exp_q.pop_front();
    n_tests++;
    if (longint'(last_t[1] - first_t[1]) !== expv) begin
      n_fail++; $display("FAIL retrig_no_gap: got span %0d expected %0d", last_t[1] - first_t[1], expv);
    end
    n_tests++;
    if (ch_on[1] !== 1'b0) begin n_fail++; $display("FAIL retrig_gated: got %b expected 0", ch_on[1]); end
  endtask

  task automatic test_test_en();
    stat_clr = 1'b1;
    test_en  = 1'b1;
    clr_edges();
    exp_q.push_back(10);
    exp_q.push_back(3);
    tick();
    stat_clr = 1'b0;
    repeat (9) tick();
    test_en = 1'b0;
    for (int i = 0; i < CH; i++) begin
      n_tests++;
      if (gate_cnt[i*SW +: SW] !== 16'd0) begin
        n_fail++; $display("FAIL test_en_frozen[%0d]: got %0d expected 0", i, gate_cnt[i*SW +: SW]);
      end
    end
    repeat (3) tick();
    expv = exp_q.pop_front();
    for (int i = 0; i < CH; i++) begin
      n_tests++;
      if (longint'(ecnt[i]) !== expv) begin n_fail++; $display("FAIL test_en_edges[%0d]: got %0d expected %0d", i, ecnt[i], expv); end
    end
    n_tests++;
    if (ch_on !== 4'b0000) begin n_fail++; $display("FAIL test_en_state: got %b expected 0000", ch_on); end
    expv = exp_q.pop_front();
    for (int i = 0; i < CH; i++) begin
      n_tests++;
      if (longint'(gate_cnt[i*SW +: SW]) !== expv) begin
        n_fail++; $display("FAIL test_en_resume[%0d]: got %0d expected %0d", i, gate_cnt[i*SW +: SW], expv);
      end
    end
  endtask

  task automatic test_reset_mid_on();
    sw_en[2] = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (ch_on[2] !== 1'b1 || gclk[2] !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: got ch_on=%b gclk=%b expected 1 1", ch_on[2], gclk[2]);
    end
    rstn = 1'b0;
    #1;
    n_tests++;
    if (ch_on[2] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ch_on: got %b expected 0", ch_on[2]); end
    @(negedge clk);
    #1;
    n_tests++;
    if (gclk[2] !== 1'b0) begin n_fail++; $display("FAIL rst_mid_gclk_low: got %b expected 0", gclk[2]); end
    clr_edges();
    tick();
    n_tests++;
    if (gclk[2] !== 1'b0 || ecnt[2] !== 0) begin
      n_fail++; $display("FAIL rst_mid_held: got gclk=%b edges=%0d expected 0 0", gclk[2], ecnt[2]);
    end
    rstn = 1'b1;
    tick();
    n_tests++;
    if (ch_on[2] !== 1'b1 || ecnt[2] !== 0) begin
      n_fail++; $display("FAIL rst_release_on: got ch_on=%b edges=%0d expected 1 0", ch_on[2], ecnt[2]);
    end
    tick();
    n_tests++;
    if (ecnt[2] !== 1) begin n_fail++; $display("FAIL rst_release_edge: got %0d expected 1", ecnt[2]); end
    sw_en[2] = 1'b0;
    repeat (12) tick();
    n_tests++;
    if (glitch !== 0) begin n_fail++; $display("FAIL glitch_free: got %0d short pulses expected 0", glitch); end
  endtask

  initial begin
    test_reset();
    test_stat_clr();
    test_busy_ch0();
    test_idle_thr();
    test_test_en();
    test_reset_mid_on();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_gating_mc.md
Name: clock_gating_mc

Overview:
- Parametrised multi-channel clock-gating controller. Successor to the single-enable 8-bit gated block.
- Each channel has a glitch-free latch-based ICG. Its enable comes from a per-channel FSM: wake on activity or software force, auto-gate after a programmable idle hysteresis.
- Per-channel saturating gated-cycle counters feed power statistics.
- Sits between the top-level clock and the clock inputs of the downstream datapath sub-blocks.

Parameters:
- CH_NUM, 4, number of gated clock channels.
- IDLE_W, 8, width of the idle-threshold and idle counter.
- STAT_W, 16, width of each gated-cycle statistics counter.

Ports:
- clk  input  1  free-running source clock.
- rstn  input  1  asynchronous active-low reset.
- test_en  input  1  scan/test override; forces all gated clocks running.
- sw_en  input  CH_NUM  per-channel software force-on.
- busy  input  CH_NUM  per-channel activity indication, synchronous to clk.
- idle_thr  input  IDLE_W  idle cycles tolerated before gating; shared by all channels.
- stat_clr  input  1  synchronous clear of all statistics counters.
- gclk  output  CH_NUM  gated clocks.
- ch_on  output  CH_NUM  registered per-channel enable (en_q), i.e. gclk is running.
- gate_cnt  output  CH_NUM*STAT_W  gated-cycle counts; channel i occupies bits [i*STAT_W +: STAT_W].

Behaviour:

Clocking and reset:
- One clock; reset is asynchronous and active-low: clk, rstn.
- Reset values: per-channel state OFF, idle counter 0, en_q 0, ch_on 0, gate_cnt 0.
- During reset, gclk is low unless test_en=1.

Per-channel FSM (2 states), evaluated at posedge clk; act = busy[i] | sw_en[i]:
- OFF, act=1: go to ON, en_q<=1, cnt<=0.
- OFF, act=0: stay OFF.
- ON, act=1: stay ON, cnt<=0.
- ON, act=0, cnt>=idle_thr: go to OFF, en_q<=0, cnt<=0.
- ON, act=0, cnt<idle_thr: cnt<=cnt+1.
- The comparison uses the live idle_thr value. Lowering it mid-count gates at the next idle edge; no wrap is possible.
- idle_thr=0: gate on the first idle edge.

Timing:
- Latency: act sampled high at edge k while OFF gives the first gclk rising edge at k+1.
- After the last edge k with act=1, gclk delivers exactly idle_thr+1 further rising edges (k+1..k+idle_thr+1), then stops.
- act pulsing high during the idle count resets cnt; there is no gap in gclk.

ICG (per channel):
- Latch transparent while clk=0, input en_q|test_en.
- gclk = clk & latch_q.
- No glitches or truncated high phases for any en_q/test_en change synchronous to clk.
- test_en is asynchronous to the FSM: it does not alter FSM state or counters, only the ICG.

Statistics:
- gate_cnt[i] increments on each posedge where en_q[i]=0 and test_en=0.
- Saturates at all-ones; no wrap.
- stat_clr=1 zeroes all counters and has priority over increment.
- Reset or stat_clr mid-count returns the counter to 0.

Reset mid-operation:
- Asserting rstn=0 while ON drops en_q immediately.
- gclk completes its current high phase at most; the latch holds until clk falls.
- On the first edge after deassertion, the channel starts in OFF.

Decomposition:
- Shared package: state encoding localparams ST_OFF=1'b0 and ST_ON=1'b1, and default widths.
- One sub-module, cg_icg_cell (latch + AND, ports clk, en, test_en, gclk), instantiated CH_NUM times in a generate loop.
- FSM, idle counter and stat counter are generated per channel inside clock_gating_mc.

Test Plan:
- Reset, then busy=0, sw_en=0, idle_thr=4 for 20 cycles -> gclk flat low, ch_on=0, each gate_cnt=20.
- busy[0] high for 3 cycles, idle_thr=4 -> gclk[0] first edge 1 cycle after busy sampled; exactly 5 edges after the last busy edge; ch_on[0] falls; other channels stay gated.
- idle_thr=0 with a single-cycle busy[1] pulse -> exactly 1 gclk[1] rising edge after the sampling edge. A second busy pulse at idle count 2 (idle_thr=6) -> cnt restarts, no gclk gap.
- test_en=1 with all channels OFF -> all gclk toggle with clk, no glitch at test_en edges; gate_cnt frozen; FSM state unchanged after test_en=0.
- STAT_W=4, channel gated 20 cycles -> gate_cnt saturates at 15. stat_clr asserted on a cycle where an increment would occur -> count 0.
- rstn pulsed low mid-ON (sw_en[2]=1) -> gclk[2] low, ch_on[2]=0 immediately; back ON 1 cycle after release since sw_en is still high.
